// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and helpers for the VGA plot sink: screen geometry, pixel
// address/colour types, the clear-sweep state encoding and the (x,y) to
// linear-address mapping used by both the plot path and the readback path.
// ---------------------------------------------------------------------------
package vga_pkg;

   typedef logic [2:0]  colour_t;     // {R,G,B}
   typedef logic [14:0] pix_addr_t;   // 0 .. NUM_PIX-1

   localparam logic [7:0] H_RES     = 8'd160;
   localparam logic [6:0] V_RES     = 7'd120;
   localparam pix_addr_t  NUM_PIX   = 15'd19200;
   localparam pix_addr_t  LAST_ADDR = NUM_PIX - 15'd1;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } clr_state_t;

   function automatic logic xy_in_range(input logic [7:0] x, input logic [6:0] y);
      return (x < H_RES) && (y < V_RES);
   endfunction

   // y*160 + x built from shifts; only meaningful for in-range coordinates.
   function automatic pix_addr_t xy_to_addr(input logic [7:0] x, input logic [6:0] y);
      pix_addr_t yw;
      yw = pix_addr_t'(y);
      return (yw << 7) + (yw << 5) + pix_addr_t'(x);
   endfunction

endpackage

// File: rtl/plot_ram.sv
// ---------------------------------------------------------------------------
// plot_ram
// 19200 x 4 shadow framebuffer: bit 3 is the written flag, bits 2:0 colour.
// One write port and two independent synchronous read ports. A read of the
// address being written in the same cycle returns the old contents.
//   clk      : clock
//   we       : write enable
//   waddr    : write address
//   wdata    : {written, colour}
//   raddr_a  : read port A address (plot-path lookup)
//   rdata_a  : read port A data, 1-cycle latency
//   raddr_b  : read port B address (readback)
//   rdata_b  : read port B data, 1-cycle latency
// ---------------------------------------------------------------------------
module plot_ram
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       we,
   input  pix_addr_t  waddr,
   input  logic [3:0] wdata,
   input  pix_addr_t  raddr_a,
   output logic [3:0] rdata_a,
   input  pix_addr_t  raddr_b,
   output logic [3:0] rdata_b
);

   logic [3:0] mem [0:NUM_PIX-1];

   // NOTE: no reset on the array or its read registers; a reset would stop
   // block-RAM inference, and the clear sweep initialises the contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
   end

endmodule

// File: rtl/vga_plot_sink.sv
// ---------------------------------------------------------------------------
// vga_plot_sink
// Receiving end of the VGA plot bus. Every accepted plot is stored in a
// shadow framebuffer with a written-map; counts distinct pixels written and
// dropped plots, and offers a synchronous readback port.
//   clk, rst              : clock, asynchronous active-high reset
//   vga_x/y/colour/plot   : plot bus, one pixel per cycle with plot high
//   clr                   : pulse, starts a clear sweep when idle
//   busy                  : clear sweep in progress (plots are dropped)
//   rd_x, rd_y            : readback coordinates
//   rd_colour, rd_written : readback data, 1-cycle latency, 0 if out of range
//   distinct              : distinct in-range pixels written since clear
//   dropped               : out-of-range or busy plots, saturating
//   full_cov              : distinct has reached every pixel
// ---------------------------------------------------------------------------
module vga_plot_sink
   import vga_pkg::*;
#(
   parameter int CNT_W = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       vga_x,
   input  logic [6:0]       vga_y,
   input  logic [2:0]       vga_colour,
   input  logic             vga_plot,
   input  logic             clr,
   output logic             busy,
   input  logic [7:0]       rd_x,
   input  logic [6:0]       rd_y,
   output logic [2:0]       rd_colour,
   output logic             rd_written,
   output logic [CNT_W-1:0] distinct,
   output logic [CNT_W-1:0] dropped,
   output logic             full_cov
);

   clr_state_t       state_q, state_d;
   pix_addr_t        sweep_addr;
   logic             sweep_we;

   logic             s0_ok, s0_accept, s0_drop;
   pix_addr_t        s0_addr;
   logic             s1_valid;
   pix_addr_t        s1_addr;
   colour_t          s1_colour;
   logic             s2_valid;
   pix_addr_t        s2_addr;
   logic             s1_seen, s1_new;

   logic             ram_we;
   pix_addr_t        ram_waddr;
   logic [3:0]       ram_wdata;
   logic [3:0]       rdata_a, rdata_b;

   logic             rd_ok, rd_ok_q;
   pix_addr_t        rd_addr;
   logic [CNT_W-1:0] distinct_inc;

   assign busy = (state_q == SWEEP);

   // S0: range check; the lookup address is presented to RAM port A now so
   // the written bit is available while the plot sits in S1.
   assign s0_ok     = xy_in_range(vga_x, vga_y);
   assign s0_accept = vga_plot && s0_ok && !busy;
   assign s0_drop   = vga_plot && !s0_accept;
   assign s0_addr   = s0_ok ? xy_to_addr(vga_x, vga_y) : '0;

   // The RAM read for the plot now in S1 happened on the same edge as the
   // previous plot's write, so it saw the old bit; forward that write.
   assign s1_seen = rdata_a[3] | (s2_valid && (s2_addr == s1_addr));
   assign s1_new  = s1_valid && !s1_seen;

   assign distinct_inc = distinct + 1'b1;

   // Sweep writes only once S1 has drained, so in-flight plots land first
   // and are then wiped.
   assign ram_we    = sweep_we | s1_valid;
   assign ram_waddr = sweep_we ? sweep_addr : s1_addr;
   assign ram_wdata = sweep_we ? 4'b0000 : {1'b1, s1_colour};

   assign rd_ok      = xy_in_range(rd_x, rd_y);
   assign rd_addr    = rd_ok ? xy_to_addr(rd_x, rd_y) : '0;
   assign rd_colour  = rd_ok_q ? rdata_b[2:0] : 3'b000;
   assign rd_written = rd_ok_q & rdata_b[3];

   plot_ram u_ram (
      .clk     (clk),
      .we      (ram_we),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .raddr_a (s0_addr),
      .rdata_a (rdata_a),
      .raddr_b (rd_addr),
      .rdata_b (rdata_b)
   );

   // NOTE: every output of this block gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      sweep_we = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr) state_d = SWEEP;
         end
         SWEEP: begin
            sweep_we = !s1_valid;
            if (sweep_we && (sweep_addr == LAST_ADDR)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= SWEEP;
         sweep_addr <= '0;
      end else begin
         state_q <= state_d;
         if (sweep_we) begin
            sweep_addr <= (sweep_addr == LAST_ADDR) ? '0 : sweep_addr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_addr   <= '0;
         s1_colour <= '0;
         s2_valid  <= 1'b0;
         s2_addr   <= '0;
         rd_ok_q   <= 1'b0;
      end else begin
         s1_valid  <= s0_accept;
         s1_addr   <= s0_addr;
         s1_colour <= vga_colour;
         s2_valid  <= s1_valid;
         s2_addr   <= s1_addr;
         rd_ok_q   <= rd_ok;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         distinct <= '0;
         dropped  <= '0;
         full_cov <= 1'b0;
      end else begin
         if (s0_drop && (dropped != '1)) begin
            dropped <= dropped + 1'b1;
         end
         // Sweep and S1 writes are mutually exclusive, so the two updates
         // never collide.
         if (sweep_we && (sweep_addr == '0)) begin
            distinct <= '0;
            full_cov <= 1'b0;
         end else if (s1_new) begin
            distinct <= distinct_inc;
            full_cov <= (distinct_inc == CNT_W'(NUM_PIX));
         end
      end
   end

endmodule

// File: tb/tb_vga_plot_sink.sv
// ---------------------------------------------------------------------------
// tb_vga_plot_sink
// Randomized and directed stimulus against a framebuffer-level reference
// model: a colour array, a written array and two counters updated whenever
// a plot strobe is driven.
// ---------------------------------------------------------------------------
module tb_vga_plot_sink;

   localparam int CNT_W = 15;
   localparam int NPIX  = 19200;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       vga_x;
   logic [6:0]       vga_y;
   logic [2:0]       vga_colour;
   logic             vga_plot;
   logic             clr;
   logic             busy;
   logic [7:0]       rd_x;
   logic [6:0]       rd_y;
   logic [2:0]       rd_colour;
   logic             rd_written;
   logic [CNT_W-1:0] distinct;
   logic [CNT_W-1:0] dropped;
   logic             full_cov;

   int checks = 0;
   int errors = 0;

   logic [2:0] m_col [0:NPIX-1];
   bit         m_wr  [0:NPIX-1];
   int         m_distinct;
   int         m_dropped;

   vga_plot_sink #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot),
      .clr        (clr),
      .busy       (busy),
      .rd_x       (rd_x),
      .rd_y       (rd_y),
      .rd_colour  (rd_colour),
      .rd_written (rd_written),
      .distinct   (distinct),
      .dropped    (dropped),
      .full_cov   (full_cov)
   );

   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int a = 0; a < NPIX; a++) begin
         m_col[a] = 3'b000;
         m_wr[a]  = 1'b0;
      end
      m_distinct = 0;
   endtask

   task automatic model_plot(input int x, input int y, input int c, input bit blocked);
      int a;
      if (x < 160 && y < 120 && !blocked) begin
         a = y * 160 + x;
         if (!m_wr[a]) begin
            m_wr[a] = 1'b1;
            m_distinct++;
         end
         m_col[a] = 3'(c);
      end else if (m_dropped < 32767) begin
         m_dropped++;
      end
   endtask

   task automatic drive_plot(input int x, input int y, input int c);
      vga_x      = 8'(x);
      vga_y      = 7'(y);
      vga_colour = 3'(c);
      vga_plot   = 1'b1;
      model_plot(x, y, c, 1'b0);
   endtask

   task automatic do_plot(input int x, input int y, input int c);
      drive_plot(x, y, c);
      tick();
   endtask

   task automatic end_plots();
      vga_plot = 1'b0;
      tick();
      tick();
   endtask

   task automatic read_check(input int x, input int y);
      int exp_c;
      int exp_w;
      rd_x = 8'(x);
      rd_y = 7'(y);
      tick();
      exp_c = 0;
      exp_w = 0;
      if (x < 160 && y < 120) begin
         exp_c = int'(m_col[y * 160 + x]);
         exp_w = int'(m_wr[y * 160 + x]);
      end
      check($sformatf("rd_colour(%0d,%0d)", x, y), 32'(rd_colour), 32'(exp_c));
      check($sformatf("rd_written(%0d,%0d)", x, y), 32'(rd_written), 32'(exp_w));
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_distinct"}, 32'(distinct), 32'(m_distinct));
      check({tag, "_dropped"}, 32'(dropped), 32'(m_dropped));
      check({tag, "_full_cov"}, 32'(full_cov), 32'(m_distinct == NPIX));
   endtask

   task automatic wait_sweep(input string tag);
      int n;
      n = 0;
      while (busy && n < 20000) begin
         tick();
         n++;
      end
      check({tag, "_sweep_len"}, 32'(n), 32'd19200);
   endtask

   initial begin
      int x, y, c, n;

      rst = 1'b1;
      vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
      clr = 1'b0; rd_x = '0; rd_y = '0;
      m_dropped = 0;
      model_clear();

      // Reset state
      tick(); tick(); tick();
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_distinct", 32'(distinct), 32'd0);
      check("rst_dropped", 32'(dropped), 32'd0);
      check("rst_full_cov", 32'(full_cov), 32'd0);
      check("rst_rd_colour", 32'(rd_colour), 32'd0);
      check("rst_rd_written", 32'(rd_written), 32'd0);
      rst = 1'b0;
      wait_sweep("init");
      check_counters("init");
      for (int k = 0; k < 8; k++) read_check($urandom_range(0, 159), $urandom_range(0, 119));

      // Single plot: counters reflect it exactly two edges after the strobe
      drive_plot(5, 7, 3'b101);
      tick();
      vga_plot = 1'b0;
      tick();
      check("single_distinct", 32'(distinct), 32'd1);
      read_check(5, 7);

      // Same pixel on three consecutive cycles counts once, last colour wins
      do_plot(10, 10, 1);
      do_plot(10, 10, 2);
      do_plot(10, 10, 4);
      end_plots();
      check("repeat_distinct", 32'(distinct), 32'd2);
      read_check(10, 10);

      // Out-of-range plots
      do_plot(160, 0, 7);
      do_plot(0, 120, 7);
      do_plot(255, 127, 7);
      end_plots();
      check_counters("oor");
      check("oor_dropped_abs", 32'(dropped), 32'd3);
      read_check(0, 0);
      read_check(200, 3);

      // Randomized bursts concentrated on a small region to force rewrites
      for (int b = 0; b < 6; b++) begin
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) begin
               if ($urandom_range(0, 7) == 0) begin
                  x = $urandom_range(0, 255);
                  y = $urandom_range(0, 127);
               end else begin
                  x = $urandom_range(0, 11);
                  y = $urandom_range(0, 7);
               end
               c = $urandom_range(0, 7);
               drive_plot(x, y, c);
            end else begin
               vga_plot = 1'b0;
            end
            tick();
         end
         end_plots();
         check_counters($sformatf("burst%0d", b));
         for (int k = 0; k < 6; k++) read_check($urandom_range(0, 11), $urandom_range(0, 7));
      end

      // Column-major fillscreen reaches full coverage
      for (int fx = 0; fx < 160; fx++) begin
         for (int fy = 0; fy < 120; fy++) begin
            do_plot(fx, fy, fx * 3 + fy);
         end
      end
      end_plots();
      check_counters("fill");
      check("fill_full_cov", 32'(full_cov), 32'd1);
      read_check(0, 0);
      read_check(159, 119);
      for (int k = 0; k < 6; k++) read_check($urandom_range(0, 159), $urandom_range(0, 119));

      // Clear sweep with a dropped plot and an ignored clr while busy
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr_busy", 32'(busy), 32'd1);
      model_clear();
      n = 0;
      while (busy && n < 20000) begin
         vga_plot = (n == 100);
         if (n == 100) begin
            vga_x = 8'd20; vga_y = 7'd20; vga_colour = 3'd3;
            model_plot(20, 20, 3, 1'b1);
         end
         clr = (n == 5000);
         tick();
         n++;
         if (n == 10) begin
            check("clr_early_distinct", 32'(distinct), 32'd0);
            check("clr_early_full_cov", 32'(full_cov), 32'd0);
         end
      end
      vga_plot = 1'b0;
      clr = 1'b0;
      check("clr_sweep_len", 32'(n), 32'd19200);
      check_counters("clr");
      read_check(20, 20);
      read_check(159, 119);
      for (int k = 0; k < 6; k++) read_check($urandom_range(0, 159), $urandom_range(0, 119));

      // Reset in the middle of a sweep
      do_plot(1, 1, 7);
      do_plot(2, 1, 6);
      end_plots();
      check_counters("pre_rst");
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int k = 0; k < 500; k++) tick();
      rst = 1'b1;
      #2;
      check("midrst_busy", 32'(busy), 32'd1);
      check("midrst_distinct", 32'(distinct), 32'd0);
      check("midrst_dropped", 32'(dropped), 32'd0);
      check("midrst_full_cov", 32'(full_cov), 32'd0);
      model_clear();
      m_dropped = 0;
      tick();
      tick();
      rst = 1'b0;
      wait_sweep("midrst");
      check_counters("post_rst");
      read_check(1, 1);
      read_check(2, 1);
      read_check(159, 119);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
